pci_ram_arb: RTL

PCI_RAM_ARB -- requirements
Module: pci_ram_arb

---
 rtl/pci_arb_pkg.sv | 16 +
 rtl/pci_arb_starve_cnt.sv | 32 +++
 rtl/pci_ram_arb.sv | 100 ++++++++++
 3 files changed

// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI / local-bus RAM arbiter.
// Holds the owner-state encoding, default geometry and starvation limit, and the RAM data width.
package pci_arb_pkg;

  localparam int DATA_W       = 32;
  localparam int ADDR_DEF     = 8;
  localparam int MAX_WAIT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PCI   = 2'd1,
    LOC   = 2'd2,
    FORCE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/pci_arb_starve_cnt.sv
// Local-port starvation counter: counts cycles a local request is refused and
// raises force_grant once the refusal streak reaches MAX_WAIT.
module pci_arb_starve_cnt
  import pci_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic PCI_CLK,
  input  logic PCI_RSTn,
  input  logic loc_req,
  input  logic loc_gnt,
  output logic force_grant
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      wait_cnt <= '0;
    end else if (loc_gnt || !loc_req) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Only force while the local request is still present, so no phantom access is issued.
  assign force_grant = (wait_cnt == WAIT_LIMIT) && loc_req;

endmodule

// File: rtl/pci_ram_arb.sv
// Single-port RAM arbiter between a PCI target and a local port; PCI wins collisions.
// Define ARB_STARVE_GUARD_EN to add the local-port starvation guard (forced local grant).
module pci_ram_arb
  import pci_arb_pkg::*;
#(
  parameter int ADDR     = ADDR_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              PCI_CLK,
  input  logic              PCI_RSTn,
  input  logic              pci_req,
  input  logic              pci_we,
  input  logic [ADDR-1:0]   pci_addr,
  input  logic [DATA_W-1:0] pci_wdata,
  output logic              pci_gnt,
  output logic              pci_wait,
  output logic              pci_rvalid,
  output logic [DATA_W-1:0] pci_rdata,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR-1:0]   loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_gnt,
  output logic              loc_rvalid,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR-1:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner
);

  if (MAX_WAIT < 2 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("pci_ram_arb: MAX_WAIT must be in 2..255");
  end

  logic       force_grant;
  arb_state_t state;
  logic       pci_vld_p1;
  logic       loc_vld_p1;

`ifdef ARB_STARVE_GUARD_EN
  pci_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_cnt (
    .PCI_CLK    (PCI_CLK),
    .PCI_RSTn   (PCI_RSTn),
    .loc_req    (loc_req),
    .loc_gnt    (loc_gnt),
    .force_grant(force_grant)
  );
`else
  assign force_grant = 1'b0;
`endif

  // Stage p0: combinational grant and RAM strobe in the request cycle
  assign pci_gnt  = pci_req & ~force_grant;
  assign loc_gnt  = loc_req & (force_grant | ~pci_req);
  assign pci_wait = pci_req & force_grant;
  assign ram_en   = pci_gnt | loc_gnt;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (pci_gnt) begin
      ram_we    = pci_we;
      ram_addr  = pci_addr;
      ram_wdata = pci_wdata;
    end else if (loc_gnt) begin
      ram_we    = loc_we;
      ram_addr  = loc_addr;
      ram_wdata = loc_wdata;
    end
  end

  // Stage p1: read-data valid and owner state, one cycle after the grant
  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      state      <= IDLE;
      pci_vld_p1 <= 1'b0;
      loc_vld_p1 <= 1'b0;
    end else begin
      pci_vld_p1 <= pci_gnt & ~pci_we;
      loc_vld_p1 <= loc_gnt & ~loc_we;
      if (pci_gnt)                     state <= PCI;
      else if (loc_gnt && force_grant) state <= FORCE;
      else if (loc_gnt)                state <= LOC;
      else                             state <= IDLE;
    end
  end

  assign owner      = state;
  assign pci_rvalid = pci_vld_p1;
  assign loc_rvalid = loc_vld_p1;
  assign pci_rdata  = pci_vld_p1 ? ram_rdata : '0;
  assign loc_rdata  = loc_vld_p1 ? ram_rdata : '0;

endmodule
